// File: rtl/cmp_serial_ge.sv
// Digit-serial magnitude comparator, LSB digit first.
// Accepts a compare with start while not busy, walks N = WIDTH/DIGIT digits
// one per clock, then pulses done with a mode-selected result and eq/gt/lt.
// Signed operands are mapped to offset-binary on capture, so a single unsigned
// serial walk covers both orderings and no subtraction is ever formed.
module cmp_serial_ge #(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 1,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic             busy,
  output logic             done,
  output logic             result,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Flipping the MSB turns two's-complement order into unsigned order.
  localparam logic [WIDTH-1:0] FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_mode;
  logic [CW-1:0]    r_cnt;
  logic             r_gt;
  logic             r_lt;
  logic             r_result;
  logic             r_eq;
  logic             r_gt_o;
  logic             r_lt_o;

  logic [DIGIT-1:0] w_da;
  logic [DIGIT-1:0] w_db;
  logic             w_gt_next;
  logic             w_lt_next;
  logic             w_eq_next;
  logic             w_res_next;
  logic             w_accept;
  logic             w_last;

  assign w_da     = r_a[DIGIT-1:0];
  assign w_db     = r_b[DIGIT-1:0];
  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == LAST);

  // Current digit decides when unequal; equal digits keep the lower-digit verdict.
  always_comb begin
    w_gt_next = r_gt;
    w_lt_next = r_lt;
    if (w_da > w_db) begin
      w_gt_next = 1'b1;
      w_lt_next = 1'b0;
    end else if (w_da < w_db) begin
      w_gt_next = 1'b0;
      w_lt_next = 1'b1;
    end
    w_eq_next = ~w_gt_next & ~w_lt_next;
  end

  // Mode decode of the final flags; 6 and 7 are reserved and read as 0.
  always_comb begin
    w_res_next = 1'b0;
    case (r_mode)
      3'd0:    w_res_next = w_gt_next | w_eq_next;
      3'd1:    w_res_next = w_gt_next;
      3'd2:    w_res_next = w_lt_next | w_eq_next;
      3'd3:    w_res_next = w_lt_next;
      3'd4:    w_res_next = w_eq_next;
      3'd5:    w_res_next = ~w_eq_next;
      default: w_res_next = 1'b0;
    endcase
  end

  // Control FSM plus operand shift registers and running gt/lt verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= '0;
      r_cnt   <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a   <= r_a >> DIGIT;
          r_b   <= r_b >> DIGIT;
          r_gt  <= w_gt_next;
          r_lt  <= w_lt_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= S_DONE;
        end
        default: begin
          if (w_accept) begin
            r_a     <= a ^ FLIP;
            r_b     <= b ^ FLIP;
            r_mode  <= mode;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Visible result and flags update only on the last digit and hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= 1'b0;
      r_eq     <= 1'b0;
      r_gt_o   <= 1'b0;
      r_lt_o   <= 1'b0;
    end else if (r_state == S_RUN && w_last) begin
      r_result <= w_res_next;
      r_eq     <= w_eq_next;
      r_gt_o   <= w_gt_next;
      r_lt_o   <= w_lt_next;
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign eq     = r_eq;
  assign gt     = r_gt_o;
  assign lt     = r_lt_o;

endmodule

// File: tb/tb_cmp_serial_ge.sv
// Bench for cmp_serial_ge: three instances (unsigned bit-serial, signed
// bit-serial, unsigned nibble-serial) driven one at a time. Expected outcomes
// are pushed to a scoreboard on accept and popped when done pulses.
module tb_cmp_serial_ge;

  logic            clk = 1'b0;
  logic [2:0]      rst;
  logic [2:0]      start;
  logic [2:0][7:0] a;
  logic [2:0][7:0] b;
  logic [2:0][2:0] mode;
  logic [2:0]      busy, done, result, eq, gt, lt;

  always #5 clk = ~clk;

  cmp_serial_ge #(.WIDTH(8), .DIGIT(1), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .a(a[0]), .b(b[0]), .mode(mode[0]),
    .busy(busy[0]), .done(done[0]), .result(result[0]), .eq(eq[0]), .gt(gt[0]), .lt(lt[0]));
  cmp_serial_ge #(.WIDTH(8), .DIGIT(1), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .a(a[1]), .b(b[1]), .mode(mode[1]),
    .busy(busy[1]), .done(done[1]), .result(result[1]), .eq(eq[1]), .gt(gt[1]), .lt(lt[1]));
  cmp_serial_ge #(.WIDTH(8), .DIGIT(4), .SIGNED(0)) u2 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .a(a[2]), .b(b[2]), .mode(mode[2]),
    .busy(busy[2]), .done(done[2]), .result(result[2]), .eq(eq[2]), .gt(gt[2]), .lt(lt[2]));

  typedef struct {
    int   idx;
    logic r, e, g, l;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int inst_n(int i);
    return (i == 2) ? 2 : 8;
  endfunction

  // Reference: plain integer compare, signed view only for instance 1.
  function automatic exp_t model(int i, logic [7:0] av, logic [7:0] bv, logic [2:0] md);
    exp_t e;
    int   x, y;
    x = (i == 1) ? int'($signed(av)) : int'(av);
    y = (i == 1) ? int'($signed(bv)) : int'(bv);
    e.idx = i;
    e.g = (x > y);
    e.l = (x < y);
    e.e = (x == y);
    case (md)
      3'd0: e.r = e.g | e.e;
      3'd1: e.r = e.g;
      3'd2: e.r = e.l | e.e;
      3'd3: e.r = e.l;
      3'd4: e.r = e.e;
      3'd5: e.r = ~e.e;
      default: e.r = 1'b0;
    endcase
    return e;
  endfunction

  // Scoreboard pop on every done; a done with nothing queued is a failure.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] === 1'b1) begin
        chk("sb_has_entry", (q.size() != 0), 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("sb_inst",   i,         e.idx);
          chk("sb_result", result[i], e.r);
          chk("sb_eq",     eq[i],     e.e);
          chk("sb_gt",     gt[i],     e.g);
          chk("sb_lt",     lt[i],     e.l);
        end
      end
    end
  end

  // Called just after a negedge; returns at the negedge following the accept.
  task automatic start_op(int i, logic [7:0] av, logic [7:0] bv, logic [2:0] md, bit expect_done);
    a[i] = av; b[i] = bv; mode[i] = md; start[i] = 1'b1;
    if (expect_done) q.push_back(model(i, av, bv, md));
    @(posedge clk);
    #1 start[i] = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", busy[i], 1);
    chk("no_done_after_accept", done[i], 0);
  endtask

  // Waits (bounded) for done; checks latency and busy-cycle count.
  task automatic wait_done(int i, int n0, int bc0, output int n);
    int bc;
    n = n0; bc = bc0;
    while (done[i] !== 1'b1 && n < 40) begin
      if (busy[i] === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    chk("latency", n, inst_n(i));
    chk("busy_cycles", bc, inst_n(i));
    chk("busy_low_at_done", busy[i], 0);
  endtask

  task automatic run(int i, logic [7:0] av, logic [7:0] bv, logic [2:0] md);
    int n;
    start_op(i, av, bv, md, 1'b1);
    wait_done(i, 0, 0, n);
    @(negedge clk);
    chk("done_one_cycle", done[i], 0);
  endtask

  initial begin
    int n, n2;
    rst = '1; start = '0; a = '0; b = '0; mode = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", busy[i], 0);
      chk("rst_done", done[i], 0);
      chk("rst_flags", {result[i], eq[i], gt[i], lt[i]}, 0);
    end
    rst = '0;
    @(negedge clk);

    // Unsigned GE, MSB decides.
    run(0, 8'h80, 8'h7F, 3'd0);
    // All modes on equal operands.
    for (int m = 0; m < 8; m++) run(0, 8'h5A, 8'h5A, 3'(m));
    // Signed vs unsigned view of 0x80 vs 0x01.
    run(1, 8'h80, 8'h01, 3'd3);
    run(0, 8'h80, 8'h01, 3'd3);
    // Extremes without overflow, both views.
    run(0, 8'h00, 8'hFF, 3'd2);
    run(1, 8'h00, 8'hFF, 3'd1);
    run(1, 8'h7F, 8'h80, 3'd5);
    run(1, 8'h80, 8'h80, 3'd4);

    // Nibble-serial, then back-to-back start in the DONE cycle.
    start_op(2, 8'h3F, 8'h40, 3'd1, 1'b1);
    wait_done(2, 0, 0, n);
    start_op(2, 8'h41, 8'h40, 3'd1, 1'b1);
    wait_done(2, 0, 0, n2);
    chk("b2b_done_spacing", n2 + 1, 3);
    @(negedge clk);

    // Random sweep over all three instances.
    for (int k = 0; k < 30; k++)
      run(k % 3, 8'($urandom_range(255)), 8'($urandom_range(255)), 3'($urandom_range(7)));

    // Reset on cycle 3 of RUN discards the compare.
    start_op(0, 8'hFF, 8'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("midrst_busy", busy[0], 0);
    chk("midrst_done", done[0], 0);
    chk("midrst_flags", {result[0], eq[0], gt[0], lt[0]}, 0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done[0] === 1'b1 || busy[0] === 1'b1) n++;
    end
    chk("midrst_quiet", n, 0);

    // Start while busy is ignored, with new operands on the pins.
    start_op(0, 8'h01, 8'h02, 3'd3, 1'b1);
    start[0] = 1'b1; a[0] = 8'hFF; b[0] = 8'h00; mode[0] = 3'd1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_done(0, 1, 1, n);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (done[0] === 1'b1) n++;
    end
    chk("ignored_start_single_done", n, 0);
    chk("sb_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/cmp_serial_ge.md
Name: cmp_serial_ge

Overview:
- Parametrised, multi-mode, digit-serial magnitude comparator; sequential successor to the single-bit combinational `cmpge` cell.
- Compares two WIDTH-bit operands DIGIT bits per clock, LSB first, under a start/busy/done handshake.
- Produces a mode-selected boolean result plus raw eq/gt/lt flags.
- Used as a fault-simulation benchmark with sequential depth, and as a low-area comparator in datapaths.

Parameters:
- WIDTH, 8, operand width in bits; must be at least 2.
- DIGIT, 1, bits compared per cycle; must divide WIDTH exactly.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; accepted only when busy=0.
- a  input  WIDTH  operand A; sampled on the accepting edge.
- b  input  WIDTH  operand B; sampled on the accepting edge.
- mode  input  3  compare select; sampled on the accepting edge.
- busy  output  1  high while digits are being processed.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  1  mode-selected comparison outcome.
- eq  output  1  A == B.
- gt  output  1  A > B.
- lt  output  1  A < B.

Behaviour:
- Reset (synchronous, active-high, clk edge with rst=1):
  - state=IDLE; busy, done, result, eq, gt, lt all 0; internal shift registers and digit counter cleared.
  - rst has priority over start and overrides any state, including mid-RUN; the partial compare is discarded and no done is produced.
- Derived quantity: N = WIDTH/DIGIT.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1, edge k:
  - Latch a, b and mode; clear gt_r and lt_r; set cnt=0; go to RUN; busy=1 from edge k; done=0.
  - When SIGNED=1, invert the MSB of both latched operands (offset-binary), so the unsigned serial compare yields the signed order.
- RUN, edges k+1 .. k+N: process one digit per edge, LSB digit first.
  - Digit compare: da = A[DIGIT-1:0], db = B[DIGIT-1:0] (unsigned).
  - da > db: gt_r=1, lt_r=0.
  - da < db: gt_r=0, lt_r=1.
  - da == db: flags hold; a higher digit overrides a lower one.
  - Both operand registers shift right by DIGIT; cnt increments.
- Edge k+N (last digit processed):
  - Go to DONE; busy=0; done=1.
  - gt=gt_next, lt=lt_next, eq=~gt_next & ~lt_next; result registered from these values on the same edge.
  - Latency: done is high exactly N cycles after the accepting edge.
- DONE:
  - Lasts one cycle; next edge goes to IDLE with done=0.
  - start=1 in DONE is accepted immediately (back-to-back), so throughput is one compare per N+1 cycles.
- start while busy=1 is ignored; latched operands are unaffected.
- result, eq, gt and lt hold their last values until the next done; they do not change on accept or during RUN.
- Mode encoding:
  - 0 GE: gt|eq
  - 1 GT: gt
  - 2 LE: lt|eq
  - 3 LT: lt
  - 4 EQ: eq
  - 5 NE: ~eq
  - 6, 7 reserved: result=0; flags still valid.
- Exactly one of eq/gt/lt is 1 after any done; all are 0 only before the first done after reset.
- Boundary values:
  - Equal operands give eq=1 regardless of SIGNED.
  - All-zeros vs all-ones is handled without overflow; no arithmetic subtraction is used.
- Inputs a, b and mode may change freely during RUN without effect.

Test Plan:
- Unsigned compare, WIDTH=8, DIGIT=1, SIGNED=0: start with a=0x80, b=0x7F, mode=0 (GE) -> busy high 8 cycles; done pulse exactly 8 cycles after accept; result=1, gt=1, eq=0, lt=0.
- Mode sweep on equal operands: a=b=0x5A, run all modes 0..7 -> results 1,0,1,0,1,0,0,0; eq=1 every time.
- Signed compare, SIGNED=1, WIDTH=8: a=0x80 (-128), b=0x01, mode=3 (LT) -> result=1, lt=1. Repeat with SIGNED=0 -> result=0, gt=1.
- Wider digits, WIDTH=8, DIGIT=4: a=0x3F, b=0x40, mode=1 (GT) -> done 2 cycles after accept; result=0, lt=1. Back-to-back start asserted in the DONE cycle with a=0x41, b=0x40 -> accepted; next done 3 cycles after the first done; gt=1.
- Reset mid-operation: accept a=0xFF, b=0x00; assert rst on cycle 3 of RUN -> next cycle state IDLE, busy=0, all outputs 0; no done pulse appears afterwards.
- Start while busy: accept a=0x01, b=0x02, then pulse start with a=0xFF, b=0x00 on cycle 2 -> ignored; single done with lt=1; busy timing unchanged.
